if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the PC and issues word fetches to instruction memory over a request/grant/response handshake. Returned instructions go into a small FIFO, paired with their PC+4. The decode side pops one {pc4, instr} entry per cycle unless stalled, and the queue is flushed on a taken-branch redirect from MEM.

Parameters:
DEPTH, 4, FIFO entries (power of two, 2..16)
RESET_PC, 32'h0000_0000, PC loaded on reset

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  asynchronous active-high reset
imem_req_o  out  1  fetch request valid
imem_addr_o  out  32  fetch address (current fetch PC)
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid (exactly one per grant, ≥1 cycle after grant)
imem_rdata_i  in  32  returned instruction
redirect_i  in  1  taken branch: flush and restart
redirect_pc_i  in  32  new fetch PC
id_stall_i  in  1  decode cannot accept (load-use hazard)
id_valid_o  out  1  head entry valid
id_pc4_o  out  32  PC+4 of head instruction
id_instr_o  out  32  head instruction

Behaviour:
- Reset (async, any time, including with a fetch outstanding) sets: fetch_pc=RESET_PC, count=0, rd/wr pointers=0, outstanding=0, drop=0.
- Reset outputs: id_valid_o=0, imem_req_o=0, id_pc4_o=0, id_instr_o=0.
- At most one fetch is outstanding.
- imem_req_o = !rst_i && !outstanding && !redirect_i && (count < DEPTH).
- imem_addr_o = fetch_pc.
- Grant (imem_req_o & imem_gnt_i):
  - outstanding<=1.
  - The issued PC is latched.
  - fetch_pc<=fetch_pc+4, wrapping mod 2^32.
- Response (imem_rvalid_i while outstanding):
  - outstanding<=0.
  - If drop=0, push {issued_pc+4, imem_rdata_i}.
  - If drop=1, discard the response and clear drop.
- Ignore imem_rvalid_i when outstanding=0.
- Pop: id_valid_o && !id_stall_i.
  - Head outputs are combinational from the FIFO head: id_valid_o=(count!=0).
  - Push and pop in the same cycle leave count unchanged.
- Full condition cannot overflow: the request gate requires count<DEPTH, and with a single outstanding fetch a slot is always reserved.
- Empty condition: a pop with count=0 is impossible because id_valid_o=0.
- Redirect (highest priority):
  - Next edge: count<=0, pointers<=0, fetch_pc<=redirect_pc_i.
  - Any pop is suppressed.
  - A response arriving in the same cycle is discarded.
  - If a fetch is still outstanding after the edge, drop<=1.
  - No request is issued in the redirect cycle. Fetch resumes the next cycle.
- A stall holds the head entry and all outputs stable. Fetching continues until the FIFO is full.
- Misaligned redirect_pc_i (bits[1:0]!=0): bits[1:0] are forced to 0.
- Latency:
  - Grant at cycle N with response at N+1 gives id_valid_o=1 in cycle N+2.
  - Empty-FIFO steady state is one instruction per 2 cycles, because of the single outstanding fetch.

Optional Feature:
IF_BUF_STATS_EN:
- When defined, adds output ports fetch_cnt_o[31:0] and flush_cnt_o[31:0]. Both reset to 0 and wrap mod 2^32.
  - fetch_cnt_o increments on every pushed entry.
  - flush_cnt_o increments by the number of discarded entries on each redirect: count, plus 1 if a response is dropped in that cycle or later.
- When undefined, these ports and their counters are absent and behaviour is otherwise identical.

Test Plan:
1. Reset release, always-grant memory with rvalid 1 cycle after grant, no stall:
   - addresses 0,4,8,...
   - id_pc4_o sequence 4,8,12 with matching instructions
   - first id_valid_o 2 cycles after the first grant
2. Hold id_stall_i=1 for 20 cycles:
   - count saturates at 4 and imem_req_o drops to 0
   - head stays pc4=4
   - after release, 4 entries pop on consecutive cycles in order
3. redirect_i with redirect_pc_i=0x100 while a fetch is outstanding and 2 entries are queued:
   - id_valid_o=0 next cycle
   - the late response is discarded
   - the next request address is 0x100 and the first valid pc4 is 0x104
4. redirect_i coincident with imem_rvalid_i and a pop:
   - no push and no pop
   - count=0, drop=0
   - next address = redirect_pc_i
5. Assert rst_i mid-operation with 3 queued and 1 outstanding:
   - outputs go to 0 immediately (asynchronously)
   - the stray rvalid after release is ignored
   - fetching restarts at RESET_PC
6. Redirect to 0xFFFF_FFFC:
   - fetch addresses 0xFFFF_FFFC then 0x0000_0000
   - id_pc4_o=0x0000_0000 for the first entry
   - with IF_BUF_STATS_EN, fetch_cnt_o=2 after 2 pushes

Source files
------------

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding word fetches and queues
// {pc+4, instr} entries for decode. Optional IF_BUF_STATS_EN adds fetch/flush counters.
module if_fetch_buffer #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        id_stall_i,
   output logic        id_valid_o,
   output logic [31:0] id_pc4_o,
   output logic [31:0] id_instr_o
`ifdef IF_BUF_STATS_EN
   ,
   output logic [31:0] fetch_cnt_o,
   output logic [31:0] flush_cnt_o
`endif
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [31:0]     fetch_pc_q, fetch_pc_d;
   logic [31:0]     issued_pc_q, issued_pc_d;
   logic            outstanding_q, outstanding_d;
   logic            drop_q, drop_d;
   logic [CntW-1:0] count_q, count_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;

   logic [31:0] pc4_mem   [DEPTH];
   logic [31:0] instr_mem [DEPTH];

   logic grant, resp, push, pop;

   assign id_valid_o  = (count_q != '0);
   assign imem_req_o  = ~rst_i & ~outstanding_q & ~redirect_i & (count_q < CntW'(DEPTH));
   assign imem_addr_o = fetch_pc_q;

   assign grant = imem_req_o & imem_gnt_i;
   assign resp  = imem_rvalid_i & outstanding_q;
   assign push  = resp & ~drop_q & ~redirect_i;
   assign pop   = id_valid_o & ~id_stall_i & ~redirect_i;

   // Head is gated so outputs read zero whenever the queue is empty, including during reset.
   assign id_pc4_o   = id_valid_o ? pc4_mem[rd_ptr_q] : 32'h0;
   assign id_instr_o = id_valid_o ? instr_mem[rd_ptr_q] : 32'h0;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      issued_pc_d   = issued_pc_q;
      outstanding_d = outstanding_q;
      drop_d        = drop_q;
      count_d       = count_q;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      if (redirect_i) begin
         fetch_pc_d    = {redirect_pc_i[31:2], 2'b00};
         count_d       = '0;
         rd_ptr_d      = '0;
         wr_ptr_d      = '0;
         outstanding_d = outstanding_q & ~resp;
         // A fetch still in flight belongs to the old path; its response must be thrown away.
         drop_d        = outstanding_q & ~resp;
      end else begin
         if (grant) begin
            outstanding_d = 1'b1;
            issued_pc_d   = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         if (resp) begin
            outstanding_d = 1'b0;
            drop_d        = 1'b0;
         end
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         if (push && !pop)      count_d = count_q + CntW'(1);
         else if (pop && !push) count_d = count_q - CntW'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_pc_q    <= RESET_PC;
         issued_pc_q   <= RESET_PC;
         outstanding_q <= 1'b0;
         drop_q        <= 1'b0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         issued_pc_q   <= issued_pc_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         count_q       <= count_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         pc4_mem[wr_ptr_q]   <= issued_pc_q + 32'd4;
         instr_mem[wr_ptr_q] <= imem_rdata_i;
      end
   end

`ifdef IF_BUF_STATS_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;

   // A flush discards the queued entries plus the in-flight fetch unless it was already doomed.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q + {31'h0, push};
      flush_cnt_d = flush_cnt_q;
      if (redirect_i) begin
         flush_cnt_d = flush_cnt_q + 32'(count_q) + {31'h0, outstanding_q & ~drop_q};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         fetch_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign fetch_cnt_o = fetch_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer: directed scenarios plus randomized traffic against a
// queue-based reference model. Define IF_BUF_STATS_EN to also check the statistics counters.
module tb_if_fetch_buffer;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        id_stall_i;
   logic        id_valid_o;
   logic [31:0] id_pc4_o;
   logic [31:0] id_instr_o;
`ifdef IF_BUF_STATS_EN
   logic [31:0] fetch_cnt_o;
   logic [31:0] flush_cnt_o;
`endif

   if_fetch_buffer #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .id_stall_i    (id_stall_i),
      .id_valid_o    (id_valid_o),
      .id_pc4_o      (id_pc4_o),
      .id_instr_o    (id_instr_o)
`ifdef IF_BUF_STATS_EN
      ,
      .fetch_cnt_o   (fetch_cnt_o),
      .flush_cnt_o   (flush_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [31:0] m_fetch;
   logic [31:0] m_issued;
   bit          m_out;
   bit          m_drop;
   logic [31:0] m_q_pc4   [$];
   logic [31:0] m_q_instr [$];
   logic [31:0] m_fetch_cnt;
   logic [31:0] m_flush_cnt;

   // Memory environment: one pending response slot
   bit          pend = 0;
   int          pend_wait = 0;
   logic [31:0] pend_addr = 32'h0;
   int          gnt_pct = 100;
   int          lat_min = 1;
   int          lat_max = 1;

   // Sampled DUT outputs (taken on the falling edge)
   logic        s_req, s_valid;
   logic [31:0] s_addr, s_pc4, s_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic void chk(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      m_fetch     = RESET_PC;
      m_issued    = RESET_PC;
      m_out       = 0;
      m_drop      = 0;
      m_q_pc4.delete();
      m_q_instr.delete();
      m_fetch_cnt = 32'h0;
      m_flush_cnt = 32'h0;
   endfunction

   function automatic bit exp_req();
      return !m_out && !redirect_i && (m_q_pc4.size() < DEPTH);
   endfunction

   function automatic void compare();
      chk("imem_req", {31'h0, s_req}, {31'h0, exp_req()});
      chk("imem_addr", s_addr, m_fetch);
      chk("id_valid", {31'h0, s_valid}, {31'h0, m_q_pc4.size() != 0});
      if (m_q_pc4.size() != 0) begin
         chk("id_pc4", s_pc4, m_q_pc4[0]);
         chk("id_instr", s_instr, m_q_instr[0]);
      end
`ifdef IF_BUF_STATS_EN
      chk("fetch_cnt", fetch_cnt_o, m_fetch_cnt);
      chk("flush_cnt", flush_cnt_o, m_flush_cnt);
`endif
   endfunction

   function automatic void model_step();
      bit grant, resp;
      grant = exp_req() && imem_gnt_i;
      resp  = imem_rvalid_i && m_out;
      if (imem_rvalid_i) pend = 0;
      if (grant) begin
         pend      = 1;
         pend_wait = $urandom_range(lat_max, lat_min);
         pend_addr = m_fetch;
      end
      if (redirect_i) begin
         m_flush_cnt += 32'(m_q_pc4.size()) + ((m_out && !m_drop) ? 32'd1 : 32'd0);
         m_q_pc4.delete();
         m_q_instr.delete();
         m_fetch = redirect_pc_i & 32'hFFFF_FFFC;
         m_out   = m_out && !resp;
         m_drop  = m_out;
      end else begin
         if (m_q_pc4.size() != 0 && !id_stall_i) begin
            void'(m_q_pc4.pop_front());
            void'(m_q_instr.pop_front());
         end
         if (resp) begin
            m_out = 0;
            if (m_drop) m_drop = 0;
            else begin
               m_q_pc4.push_back(m_issued + 32'd4);
               m_q_instr.push_back(imem_rdata_i);
               m_fetch_cnt += 32'd1;
            end
         end
         if (grant) begin
            m_out    = 1;
            m_issued = m_fetch;
            m_fetch  = m_fetch + 32'd4;
         end
      end
   endfunction

   // Called just after a rising edge; returns just after the next rising edge.
   task automatic run_cycle(input bit stall, input bit redir, input logic [31:0] rpc);
      bit rv;
      if (pend) pend_wait--;
      rv = pend && (pend_wait <= 0);
      imem_rvalid_i = rv;
      imem_rdata_i  = rv ? mem_word(pend_addr) : $urandom();
      imem_gnt_i    = !pend && ($urandom_range(99, 0) < gnt_pct);
      id_stall_i    = stall;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      @(negedge clk_i);
      s_req   = imem_req_o;
      s_addr  = imem_addr_o;
      s_valid = id_valid_o;
      s_pc4   = id_pc4_o;
      s_instr = id_instr_o;
      compare();
      model_step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic async_reset();
      #2 rst_i = 1'b1;
      #1;
      chk("rst_req", {31'h0, imem_req_o}, 32'h0);
      chk("rst_valid", {31'h0, id_valid_o}, 32'h0);
      chk("rst_pc4", id_pc4_o, 32'h0);
      chk("rst_instr", id_instr_o, 32'h0);
      model_reset();
      @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   initial begin
      bit found;
      rst_i         = 1'b1;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
      redirect_i    = 1'b0;
      redirect_pc_i = 32'h0;
      id_stall_i    = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;

      // 1: always-grant, one-cycle latency, no stall
      gnt_pct = 100; lat_min = 1; lat_max = 1;
      for (int c = 0; c < 7; c++) begin
         run_cycle(0, 0, 32'h0);
         if (c == 0) begin
            chk("t1_req0", {31'h0, s_req}, 32'h1);
            chk("t1_addr0", s_addr, 32'h0);
         end
         if (c == 1) chk("t1_valid1", {31'h0, s_valid}, 32'h0);
         if (c == 2) begin
            chk("t1_valid2", {31'h0, s_valid}, 32'h1);
            chk("t1_pc4_a", s_pc4, 32'h4);
            chk("t1_instr_a", s_instr, mem_word(32'h0));
            chk("t1_addr2", s_addr, 32'h4);
         end
         if (c == 3) chk("t1_valid3", {31'h0, s_valid}, 32'h0);
         if (c == 4) chk("t1_pc4_b", s_pc4, 32'h8);
         if (c == 6) chk("t1_pc4_c", s_pc4, 32'hC);
      end

      // 2: long stall fills the queue, then drains in order
      async_reset();
      for (int c = 0; c < 20; c++) run_cycle(1, 0, 32'h0);
      chk("t2_req_full", {31'h0, s_req}, 32'h0);
      chk("t2_head", s_pc4, 32'h4);
      for (int k = 0; k < 4; k++) begin
         run_cycle(0, 0, 32'h0);
         chk("t2_drain_valid", {31'h0, s_valid}, 32'h1);
         chk("t2_drain_pc4", s_pc4, 32'(4 * (k + 1)));
      end

      // 3: redirect with 2 queued and a fetch outstanding (late response)
      async_reset();
      lat_min = 3; lat_max = 3;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         run_cycle(1, 0, 32'h0);
         if (m_q_pc4.size() == 2 && m_out) found = 1;
      end
      chk("t3_setup", {31'h0, found}, 32'h1);
      run_cycle(0, 1, 32'h100);
      run_cycle(0, 0, 32'h0);
      chk("t3_valid_after", {31'h0, s_valid}, 32'h0);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         run_cycle(0, 0, 32'h0);
         if (s_req) found = 1;
      end
      chk("t3_req_seen", {31'h0, found}, 32'h1);
      chk("t3_addr", s_addr, 32'h100);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         run_cycle(1, 0, 32'h0);
         if (s_valid) found = 1;
      end
      chk("t3_valid_seen", {31'h0, found}, 32'h1);
      chk("t3_pc4", s_pc4, 32'h104);

      // 4: redirect coincident with response and pop
      async_reset();
      lat_min = 1; lat_max = 1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         run_cycle(1, 0, 32'h0);
         if (m_q_pc4.size() == 1 && pend && pend_wait == 1) found = 1;
      end
      chk("t4_setup", {31'h0, found}, 32'h1);
      run_cycle(0, 1, 32'h0000_2468);
      chk("t4_valid_in", {31'h0, s_valid}, 32'h1);
      run_cycle(0, 0, 32'h0);
      chk("t4_valid_after", {31'h0, s_valid}, 32'h0);
      chk("t4_req", {31'h0, s_req}, 32'h1);
      chk("t4_addr", s_addr, 32'h0000_2468);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         run_cycle(1, 0, 32'h0);
         if (s_valid) found = 1;
      end
      chk("t4_pc4", s_pc4, 32'h0000_246C);

      // 5: asynchronous reset with 3 queued and 1 outstanding
      async_reset();
      lat_min = 2; lat_max = 2;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         run_cycle(1, 0, 32'h0);
         if (m_q_pc4.size() == 3 && m_out) found = 1;
      end
      chk("t5_setup", {31'h0, found}, 32'h1);
      async_reset();
      run_cycle(0, 0, 32'h0);
      chk("t5_req", {31'h0, s_req}, 32'h1);
      chk("t5_addr", s_addr, RESET_PC);
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         run_cycle(1, 0, 32'h0);
         if (s_valid) found = 1;
      end
      chk("t5_pc4", s_pc4, RESET_PC + 32'd4);
      chk("t5_instr", s_instr, mem_word(RESET_PC));

      // 6: redirect to the top of the address space wraps to zero
      async_reset();
      lat_min = 1; lat_max = 1;
      run_cycle(0, 1, 32'hFFFF_FFFC);
      run_cycle(0, 0, 32'h0);
      chk("t6_addr0", s_addr, 32'hFFFF_FFFC);
      run_cycle(0, 0, 32'h0);
      run_cycle(0, 0, 32'h0);
      chk("t6_pc4", s_pc4, 32'h0);
      chk("t6_addr1", s_addr, 32'h0);
      run_cycle(0, 0, 32'h0);
      run_cycle(0, 0, 32'h0);
`ifdef IF_BUF_STATS_EN
      chk("t6_fetch_cnt", fetch_cnt_o, 32'd2);
`endif

      // Randomized traffic
      async_reset();
      gnt_pct = 70; lat_min = 1; lat_max = 3;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(199, 0) == 0) async_reset();
         else run_cycle($urandom_range(99, 0) < 30, $urandom_range(99, 0) < 4, $urandom());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

endmodule
